// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline stage register.
//               Holds the stage occupancy encoding and the MEM/WB payload
//               layout used when the stage stands in for MEM2WB.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Stage occupancy: EMPTY, main register valid, main and skid valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // MEM/WB payload layout, LSB first: write_reg_address, alu_result,
    // read_data, op_type.
    localparam int MEM2WB_WREG_W      = 5;
    localparam int MEM2WB_ALU_W       = 32;
    localparam int MEM2WB_RDATA_W     = 32;
    localparam int MEM2WB_OP_W        = 4;
    localparam int MEM2WB_DATA_W      = 73;

    localparam int MEM2WB_WREG_LSB    = 0;
    localparam int MEM2WB_ALU_LSB     = MEM2WB_WREG_LSB  + MEM2WB_WREG_W;
    localparam int MEM2WB_RDATA_LSB   = MEM2WB_ALU_LSB   + MEM2WB_ALU_W;
    localparam int MEM2WB_OP_LSB      = MEM2WB_RDATA_LSB + MEM2WB_RDATA_W;

    // A zero op_type is a bubble, so an all-zero payload is a harmless NOP
    localparam logic [MEM2WB_OP_W-1:0] OP_NOP = 4'd0;

    // Assemble a MEM/WB payload from its fields
    function automatic logic [MEM2WB_DATA_W-1:0] mem2wb_pack(
        input logic [MEM2WB_OP_W-1:0]    op_type,
        input logic [MEM2WB_RDATA_W-1:0] read_data,
        input logic [MEM2WB_ALU_W-1:0]   alu_result,
        input logic [MEM2WB_WREG_W-1:0]  write_reg_address
    );
        return {op_type, read_data, alu_result, write_reg_address};
    endfunction

    // Extract the op_type field from a MEM/WB payload
    function automatic logic [MEM2WB_OP_W-1:0] mem2wb_op(
        input logic [MEM2WB_DATA_W-1:0] payload
    );
        return payload[MEM2WB_OP_LSB +: MEM2WB_OP_W];
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sat_counter
// Description : Up-counter that sticks at its all-ones value instead of
//               wrapping. Asynchronous active-high reset clears it.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Advance on inc unless already at the ceiling
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : pipe_sat_counter
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline stage register with a 2-entry skid
//               buffer. in_ready is decoded from the state register only, so
//               downstream back-pressure never reaches upstream in the same
//               cycle. flush drops every held entry and leaves a bubble.
//               Optional macro PIPE_STAGE_PERF_EN adds saturating stall and
//               bubble counters on perf_stall_cnt / perf_bubble_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = 73,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
    parameter int                 CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_bubble_cnt
`endif
);

    stage_state_e      state_q;
    stage_state_e      state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;

    logic              in_fire;
    logic              out_fire;

    // Ready/valid decode straight from the state register
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    // Main may hold a stale entry after draining, so mask it when empty
    assign out_data  = (state_q == ST_EMPTY) ? BUBBLE_VAL : main_q;

    assign in_fire   = in_valid  & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next-state and datapath selection; flush overrides everything
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // An entry accepted this cycle is dropped; one leaving completes
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end else if (in_fire) begin
                        // Downstream stalled: park the newcomer behind main
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic stall_inc;
    logic bubble_inc;

    assign stall_inc  = out_valid & ~out_ready;
    assign bubble_inc = ~out_valid;

    // Cycles an entry waits on downstream; untouched by flush
    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (perf_stall_cnt)
    );

    // Cycles the stage presents no entry; untouched by flush
    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bubble_inc),
        .cnt (perf_bubble_cnt)
    );
`else
    // Counter width only matters when the counters exist
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule : pipe_stage_reg
`default_nettype wire
